// File: rtl/data_ram_responder_if.sv
// Memory-port bundle between the data cache (master) and the RAM responder (slave).
interface data_ram_responder_if;
    logic        ce_i;
    logic        we_i;
    logic        burst_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        last_o;
    logic        busy_o;

    modport master (
        output ce_i, we_i, burst_i, addr_i, sel_i, data_i,
        input  data_o, ack_o, last_o, busy_o
    );

    modport slave (
        input  ce_i, we_i, burst_i, addr_i, sel_i, data_i,
        output data_o, ack_o, last_o, busy_o
    );
endinterface

// File: rtl/data_ram_responder.sv
// RAM-side responder for the data cache: byte-masked single reads/writes and
// aligned burst refills, answered after a fixed latency with one ack per word.
module data_ram_responder #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int LATENCY   = 3,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    data_ram_responder_if.slave  bus
);
    localparam int LAT_W  = (LATENCY > 1)   ? $clog2(LATENCY)   : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;     // burst requests store the aligned base
    logic                we_q, we_d;
    logic                burst_q, burst_d;
    logic [3:0]          sel_q, sel_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [31:0]         mem [0:DEPTH-1];
    logic [31:0]         rd_q;
    logic [ADDR_W-1:0]   rd_idx;
    logic [ADDR_W-1:0]   req_idx;
    logic                req_burst;
    logic                is_last;
    logic                unused_addr_bits;

    assign req_idx          = bus.addr_i[ADDR_W+1:2];
    assign req_burst        = bus.burst_i & ~bus.we_i;
    assign unused_addr_bits = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};
    assign is_last          = (state_q == XFER) && (!burst_q || beat_q == LAST_BEAT);

    // Outputs are decoded from registered state so reset clears them immediately.
    assign bus.ack_o  = (state_q == XFER);
    assign bus.last_o = is_last;
    assign bus.busy_o = (state_q != IDLE);
    assign bus.data_o = (state_q == XFER && !we_q) ? rd_q : 32'd0;

    // Address presented to the RAM read port: the word needed in the next cycle.
    always_comb begin
        rd_idx = idx_q;
        unique case (state_q)
            IDLE:    rd_idx = req_burst ? (req_idx & ~BLK_MASK) : req_idx;
            WAIT:    rd_idx = idx_q;
            XFER:    rd_idx = idx_q | ADDR_W'(beat_q + 1'b1);
            default: rd_idx = idx_q;
        endcase
    end

    // Next-state logic: accept in IDLE, count latency in WAIT, stream beats in XFER.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        we_d    = we_q;
        burst_d = burst_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ce_i) begin
                    idx_d   = req_burst ? (req_idx & ~BLK_MASK) : req_idx;
                    we_d    = bus.we_i;
                    burst_d = req_burst;
                    sel_d   = bus.sel_i;
                    wdata_d = bus.data_i;
                    lat_d   = LAT_W'(LATENCY - 1);
                    beat_d  = '0;
                    state_d = (LATENCY == 1) ? XFER : WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - 1'b1;
                if (lat_q == LAT_W'(1)) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (is_last) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and captured-request registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
        end
    end

    // Backing RAM: byte-masked write at the end of the ack cycle, registered read.
    always_ff @(posedge clk) begin
        if (state_q == XFER && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
        rd_q <= mem[rd_idx];
    end
endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized and directed bench for data_ram_responder with a word-array model.
module tb_data_ram_responder;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int LAT    = 3;
    localparam int BL     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_ram_responder_if bus ();
    data_ram_responder_if bus1 ();

    data_ram_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT), .BURST_LEN(BL))
        dut (.clk(clk), .rst(rst), .bus(bus));

    data_ram_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(1), .BURST_LEN(BL))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;
    logic [31:0] model [0:DEPTH-1];

    // One complete transaction on the LATENCY=3 instance, checked against the model.
    task automatic xact(input logic we, input logic burst, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd);
        logic [ADDR_W-1:0] idx, base, w;
        logic [31:0] exp;
        bit isb;
        int n, cyc;
        isb  = burst && !we;
        idx  = addr[ADDR_W+1:2];
        base = isb ? (idx & ~ADDR_W'(BL - 1)) : idx;
        n    = isb ? BL : 1;
        @(negedge clk);
        bus.ce_i = 1'b1; bus.we_i = we; bus.burst_i = burst;
        bus.addr_i = addr; bus.sel_i = sel; bus.data_i = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!bus.ack_o) begin
                total++;
                if (bus.busy_o !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_wait got=%b exp=1 cyc=%0d", bus.busy_o, cyc);
                end
            end
        end while (!bus.ack_o && cyc < LAT + 8);
        bus.ce_i = 1'b0;
        total++;
        if (cyc !== LAT) begin
            bad++;
            $display("FAIL latency got=%0d exp=%0d addr=%h", cyc, LAT, addr);
        end
        if (!bus.ack_o) return;
        for (int b = 0; b < n; b++) begin
            if (b > 0) @(negedge clk);
            w   = base + ADDR_W'(b);
            exp = we ? 32'd0 : model[w];
            total++;
            if (bus.ack_o !== 1'b1 || bus.data_o !== exp || bus.last_o !== (b == n - 1)) begin
                bad++;
                $display("FAIL beat%0d ack=%b data=%h last=%b exp ack=1 data=%h last=%b",
                         b, bus.ack_o, bus.data_o, bus.last_o, exp, (b == n - 1));
            end
        end
        if (we) begin
            for (int k = 0; k < 4; k++)
                if (sel[k]) model[idx][8*k +: 8] = wd[8*k +: 8];
        end
        @(negedge clk);
        total++;
        if (bus.ack_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL after_xact ack=%b busy=%b exp 0 0", bus.ack_o, bus.busy_o);
        end
        $display("xact we=%0d burst=%0d addr=%h sel=%b wd=%h beats=%0d", we, burst, addr, sel, wd, n);
    endtask

    task automatic test_reset();
        bus.ce_i = 0; bus.we_i = 0; bus.burst_i = 0; bus.addr_i = 0; bus.sel_i = 0; bus.data_i = 0;
        bus1.ce_i = 0; bus1.we_i = 0; bus1.burst_i = 0; bus1.addr_i = 0; bus1.sel_i = 0; bus1.data_i = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.ack_o !== 0 || bus.last_o !== 0 || bus.busy_o !== 0 || bus.data_o !== 0) begin
            bad++;
            $display("FAIL reset ack=%b last=%b busy=%b data=%h exp all 0",
                     bus.ack_o, bus.last_o, bus.busy_o, bus.data_o);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_init();
        for (int i = 0; i < 64; i++) xact(1'b1, 1'b0, 32'(i * 4), 4'hF, $urandom);
    endtask

    task automatic test_single();
        xact(1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
        xact(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
    endtask

    task automatic test_byte_mask();
        xact(1'b1, 1'b0, 32'h20, 4'hF, 32'hAABBCCDD);
        xact(1'b1, 1'b0, 32'h20, 4'b0101, 32'h11223344);
        xact(1'b0, 1'b0, 32'h20, 4'hF, 32'h0);
        total++;
        if (bus.data_o !== 32'h0) begin
            bad++;
            $display("FAIL idle_data got=%h exp=0", bus.data_o);
        end
        xact(1'b1, 1'b0, 32'h20, 4'b0000, 32'h55555555);
        xact(1'b0, 1'b0, 32'h20, 4'hF, 32'h0);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) xact(1'b1, 1'b0, 32'(48 + 4 * i), 4'hF, 32'(i + 1));
        xact(1'b0, 1'b1, 32'h34, 4'hF, 32'h0);
        xact(1'b1, 1'b1, 32'h38, 4'hF, 32'h77665544);
        xact(1'b0, 1'b1, 32'h3C, 4'hF, 32'h0);
    endtask

    task automatic test_ignore_busy();
        int acks;
        logic [31:0] got;
        acks = 0;
        got  = 32'h0;
        @(negedge clk);
        bus.ce_i = 1; bus.we_i = 0; bus.burst_i = 0; bus.addr_i = 32'h10; bus.sel_i = 4'hF;
        @(negedge clk);
        bus.ce_i = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.ack_o) begin
                acks++;
                got = bus.data_o;
            end
            if (i == 1) begin
                bus.ce_i = 1; bus.we_i = 1; bus.addr_i = 32'h24; bus.data_i = 32'h5A5A5A5A;
            end
            if (i == 2) bus.ce_i = 0;
            @(negedge clk);
        end
        bus.we_i = 0;
        total++;
        if (acks !== 1 || got !== model[4]) begin
            bad++;
            $display("FAIL ignore_busy acks=%0d data=%h exp acks=1 data=%h", acks, got, model[4]);
        end
        $display("ignore_busy acks=%0d", acks);
        xact(1'b0, 1'b0, 32'h24, 4'hF, 32'h0);
    endtask

    task automatic test_rst_wait();
        xact(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        @(negedge clk);
        bus.ce_i = 1; bus.we_i = 1; bus.burst_i = 0; bus.addr_i = 32'h40;
        bus.sel_i = 4'hF; bus.data_i = 32'h12345678;
        @(negedge clk);
        bus.ce_i = 0;
        #1 rst = 1'b1;
        #1;
        total++;
        if (bus.ack_o !== 0 || bus.last_o !== 0 || bus.busy_o !== 0 || bus.data_o !== 0) begin
            bad++;
            $display("FAIL async_reset ack=%b last=%b busy=%b data=%h exp all 0",
                     bus.ack_o, bus.last_o, bus.busy_o, bus.data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset during WAIT applied");
        xact(1'b0, 1'b0, 32'h40, 4'hF, 32'h0);
    endtask

    task automatic test_alias();
        xact(1'b1, 1'b0, 32'h1000, 4'hF, 32'hA11A5000);
        xact(1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    endtask

    task automatic test_latency_one();
        @(negedge clk);
        bus1.ce_i = 1; bus1.we_i = 1; bus1.burst_i = 0; bus1.addr_i = 32'h8;
        bus1.sel_i = 4'hF; bus1.data_i = 32'hCAFEF00D;
        @(negedge clk);
        bus1.ce_i = 0;
        total++;
        if (bus1.ack_o !== 1 || bus1.last_o !== 1) begin
            bad++;
            $display("FAIL lat1_write ack=%b last=%b exp 1 1", bus1.ack_o, bus1.last_o);
        end
        @(negedge clk);
        bus1.ce_i = 1; bus1.we_i = 0;
        @(negedge clk);
        bus1.ce_i = 0;
        total++;
        if (bus1.ack_o !== 1 || bus1.data_o !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL lat1_read ack=%b data=%h exp ack=1 data=cafef00d", bus1.ack_o, bus1.data_o);
        end
        @(negedge clk);
        total++;
        if (bus1.ack_o !== 0 || bus1.busy_o !== 0) begin
            bad++;
            $display("FAIL lat1_idle ack=%b busy=%b exp 0 0", bus1.ack_o, bus1.busy_o);
        end
        $display("latency1 write/read done");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int t = 0; t < 60; t++) begin
            a = ($urandom & ~32'h00000FFC) | 32'($urandom_range(0, 63) << 2);
            xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_single();
        test_byte_mask();
        test_burst();
        test_ignore_busy();
        test_rst_wait();
        test_alias();
        test_latency_one();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
